// File: rtl/tx_seq_pkg.sv
// Shared FSM encodings, PCLK width codes and a config helper for the Tx bring-up sequencer.
package tx_seq_pkg;

    typedef enum logic [2:0] {
        S_RST   = 3'd0,
        S_PLL   = 3'd1,
        S_ENB   = 3'd2,
        S_PS    = 3'd3,
        S_SP    = 3'd4,
        S_CONV  = 3'd5,
        S_RUN   = 3'd6,
        S_RECFG = 3'd7
    } state_e;

    localparam logic [1:0] W32   = 2'b00;
    localparam logic [1:0] W16   = 2'b01;
    localparam logic [1:0] W8    = 2'b10;
    localparam logic [1:0] WRSVD = 2'b11;

    function automatic int max5(input int a, input int b, input int c, input int d, input int e);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        if (e > m) m = e;
        return m;
    endfunction

endpackage

// File: rtl/tx_seq_timer.sv
// Loadable down-counter that sticks at zero; load has priority over decrement.
module tx_seq_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = load_val;
        else if (dec && cnt_q != '0)
            cnt_d = cnt_q - CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/tx_bringup_seq.sv
// Tx PHY bring-up sequencer and PCLK width-change controller.
// Define TX_BRINGUP_LOCK_TIMEOUT_EN to add the PLL lock watchdog and LOCK_ERR flag.
module tx_bringup_seq
    import tx_seq_pkg::*;
#(
    parameter int PLL_WAIT     = 1,
    parameter int ENB_WAIT     = 19,
    parameter int PS_WAIT      = 1,
    parameter int CONV_WAIT    = 10,
    parameter int LOCK_TIMEOUT = 255,
    parameter int CNT_W        = 8
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       PLL_LOCK,
    input  logic [1:0] WIDTH_REQ,
    input  logic       WIDTH_VALID,
    output logic       WIDTH_ACK,
    output logic [1:0] PCLK,
    output logic       ENB,
    output logic       RESET_PLL,
    output logic       RESET_PS,
    output logic       RESET_SP,
    output logic       RESET_CONV832,
    output logic       READY,
    output logic [2:0] STATE,
    output logic       LOCK_ERR
);

    localparam logic [CNT_W-1:0] LD_PLL  = CNT_W'(PLL_WAIT - 1);
    localparam logic [CNT_W-1:0] LD_ENB  = CNT_W'(ENB_WAIT - 1);
    localparam logic [CNT_W-1:0] LD_PS   = CNT_W'(PS_WAIT - 1);
    localparam logic [CNT_W-1:0] LD_CONV = CNT_W'(CONV_WAIT - 1);

    generate
        if (CNT_W < $clog2(max5(PLL_WAIT, ENB_WAIT, PS_WAIT, CONV_WAIT, LOCK_TIMEOUT) + 1)) begin : g_cnt_w_small
            $error("CNT_W too narrow for configured waits");
        end
    endgenerate

    state_e     state_q, state_d;
    logic [1:0] pclk_q, pclk_d;
    logic       rpll_q, rpll_d, enb_q, enb_d, rps_q, rps_d, rsp_q, rsp_d;
    logic       rconv_q, rconv_d, ready_q, ready_d, ack_q, ack_d;
    logic       t_load, t_dec, t_zero;
    logic [CNT_W-1:0] t_val;
    logic       lock_lost;
`ifdef TX_BRINGUP_LOCK_TIMEOUT_EN
    logic [CNT_W-1:0] wd_q, wd_d;
    logic             lerr_q, lerr_d;
`endif

    tx_seq_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (CLK),
        .rst      (RESET),
        .load     (t_load),
        .load_val (t_val),
        .dec      (t_dec),
        .zero     (t_zero)
    );

    assign lock_lost = !PLL_LOCK && state_q != S_RST && state_q != S_PLL;

    always_comb begin
        state_d = state_q;
        pclk_d  = pclk_q;
        rpll_d  = rpll_q;
        enb_d   = enb_q;
        rps_d   = rps_q;
        rsp_d   = rsp_q;
        rconv_d = rconv_q;
        ready_d = ready_q;
        ack_d   = 1'b0;
        t_load  = 1'b0;
        t_val   = '0;
        t_dec   = 1'b0;
`ifdef TX_BRINGUP_LOCK_TIMEOUT_EN
        wd_d    = wd_q;
        lerr_d  = lerr_q;
`endif
        // Lock loss outranks everything, including a pending width request.
        if (lock_lost) begin
            enb_d   = 1'b0;
            rps_d   = 1'b0;
            rsp_d   = 1'b0;
            rconv_d = 1'b0;
            ready_d = 1'b0;
            state_d = S_PLL;
            t_load  = 1'b1;
            t_val   = LD_PLL;
        end else begin
            case (state_q)
                S_RST: begin
                    rpll_d  = 1'b1;
                    state_d = S_PLL;
                    t_load  = 1'b1;
                    t_val   = LD_PLL;
                end
                S_PLL: begin
                    if (!t_zero) begin
                        t_dec = 1'b1;
                    end else if (PLL_LOCK) begin
                        enb_d   = 1'b1;
                        state_d = S_ENB;
                        t_load  = 1'b1;
                        t_val   = LD_ENB;
`ifdef TX_BRINGUP_LOCK_TIMEOUT_EN
                        wd_d    = '0;
                    end else if (wd_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
                        // One-cycle PLL reset pulse; S_RST re-releases it next edge.
                        rpll_d  = 1'b0;
                        lerr_d  = 1'b1;
                        wd_d    = '0;
                        state_d = S_RST;
                    end else begin
                        wd_d    = wd_q + CNT_W'(1);
`endif
                    end
                end
                S_ENB: begin
                    if (!t_zero) t_dec = 1'b1;
                    else begin
                        rps_d   = 1'b1;
                        state_d = S_PS;
                        t_load  = 1'b1;
                        t_val   = LD_PS;
                    end
                end
                S_PS: begin
                    // S_SP is a single staging cycle before the converter hold.
                    if (!t_zero) t_dec = 1'b1;
                    else begin
                        rsp_d   = 1'b1;
                        state_d = S_SP;
                        t_load  = 1'b1;
                        t_val   = '0;
                    end
                end
                S_SP: begin
                    if (!t_zero) t_dec = 1'b1;
                    else begin
                        state_d = S_CONV;
                        t_load  = 1'b1;
                        t_val   = LD_CONV;
                    end
                end
                S_CONV, S_RECFG: begin
                    if (!t_zero) t_dec = 1'b1;
                    else begin
                        rconv_d = 1'b1;
                        ready_d = 1'b1;
                        state_d = S_RUN;
                    end
                end
                S_RUN: begin
                    if (WIDTH_VALID && !ack_q && WIDTH_REQ != WRSVD) begin
                        ack_d = 1'b1;
                        if (WIDTH_REQ != pclk_q) begin
                            pclk_d  = WIDTH_REQ;
                            rconv_d = 1'b0;
                            ready_d = 1'b0;
                            state_d = S_RECFG;
                            t_load  = 1'b1;
                            t_val   = LD_CONV;
                        end
                    end
                end
                default: state_d = S_RST;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= S_RST;
            pclk_q  <= W32;
            rpll_q  <= 1'b0;
            enb_q   <= 1'b0;
            rps_q   <= 1'b0;
            rsp_q   <= 1'b0;
            rconv_q <= 1'b0;
            ready_q <= 1'b0;
            ack_q   <= 1'b0;
`ifdef TX_BRINGUP_LOCK_TIMEOUT_EN
            wd_q    <= '0;
            lerr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pclk_q  <= pclk_d;
            rpll_q  <= rpll_d;
            enb_q   <= enb_d;
            rps_q   <= rps_d;
            rsp_q   <= rsp_d;
            rconv_q <= rconv_d;
            ready_q <= ready_d;
            ack_q   <= ack_d;
`ifdef TX_BRINGUP_LOCK_TIMEOUT_EN
            wd_q    <= wd_d;
            lerr_q  <= lerr_d;
`endif
        end
    end

    assign WIDTH_ACK     = ack_q;
    assign PCLK          = pclk_q;
    assign ENB           = enb_q;
    assign RESET_PLL     = rpll_q;
    assign RESET_PS      = rps_q;
    assign RESET_SP      = rsp_q;
    assign RESET_CONV832 = rconv_q;
    assign READY         = ready_q;
    assign STATE         = state_q;
`ifdef TX_BRINGUP_LOCK_TIMEOUT_EN
    assign LOCK_ERR      = lerr_q;
`else
    assign LOCK_ERR      = 1'b0;
`endif

endmodule

// File: tb/tb_tx_bringup_seq.sv
// Directed bench for tx_bringup_seq: bring-up timing, width handshake, lock loss, async reset.
module tb_tx_bringup_seq;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       PLL_LOCK;
    logic [1:0] WIDTH_REQ;
    logic       WIDTH_VALID;
    logic       WIDTH_ACK;
    logic [1:0] PCLK;
    logic       ENB, RESET_PLL, RESET_PS, RESET_SP, RESET_CONV832, READY;
    logic [2:0] STATE;
    logic       LOCK_ERR;

    int ncmp  = 0;
    int nfail = 0;

    tx_bringup_seq dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .PLL_LOCK      (PLL_LOCK),
        .WIDTH_REQ     (WIDTH_REQ),
        .WIDTH_VALID   (WIDTH_VALID),
        .WIDTH_ACK     (WIDTH_ACK),
        .PCLK          (PCLK),
        .ENB           (ENB),
        .RESET_PLL     (RESET_PLL),
        .RESET_PS      (RESET_PS),
        .RESET_SP      (RESET_SP),
        .RESET_CONV832 (RESET_CONV832),
        .READY         (READY),
        .STATE         (STATE),
        .LOCK_ERR      (LOCK_ERR)
    );

    always #5 CLK = ~CLK;

    // {RESET_PLL, ENB, RESET_PS, RESET_SP, RESET_CONV832, READY}
    wire [5:0] lines = {RESET_PLL, ENB, RESET_PS, RESET_SP, RESET_CONV832, READY};

    task automatic tick(input int n = 1);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_core(input string tag, input logic [5:0] l, input logic [2:0] st,
                            input logic [1:0] pc, input logic ack);
        chk({tag, ".lines"}, {2'b0, lines}, {2'b0, l});
        chk({tag, ".state"}, {5'b0, STATE}, {5'b0, st});
        chk({tag, ".pclk"},  {6'b0, PCLK},  {6'b0, pc});
        chk({tag, ".ack"},   {7'b0, WIDTH_ACK}, {7'b0, ack});
    endtask

    initial begin
        RESET = 1'b1; PLL_LOCK = 1'b1; WIDTH_REQ = 2'b00; WIDTH_VALID = 1'b0;

        // Test 1: default bring-up with lock already high
        tick(2);
        chk_core("rst", 6'b000000, 3'd0, 2'b00, 1'b0);
        chk("rst.lock_err", {7'b0, LOCK_ERR}, 8'h0);
        RESET = 1'b0;
        tick();   // E0
        chk_core("e0", 6'b100000, 3'd1, 2'b00, 1'b0);
        tick();   // E0+1
        chk_core("e1", 6'b110000, 3'd2, 2'b00, 1'b0);
        tick(18); // E0+19
        chk_core("e19", 6'b110000, 3'd2, 2'b00, 1'b0);
        tick();   // E0+20
        chk_core("e20", 6'b111000, 3'd3, 2'b00, 1'b0);
        tick();   // E0+21
        chk_core("e21", 6'b111100, 3'd4, 2'b00, 1'b0);
        tick(10); // E0+31
        chk_core("e31", 6'b111100, 3'd5, 2'b00, 1'b0);
        tick();   // E0+32
        chk_core("e32", 6'b111111, 3'd6, 2'b00, 1'b0);

        // Test 3: width change to 8b re-sequences only the converter
        WIDTH_REQ = 2'b10; WIDTH_VALID = 1'b1;
        tick();   // A
        chk_core("wc.a", 6'b111100, 3'd7, 2'b10, 1'b1);
        WIDTH_VALID = 1'b0;
        tick();   // A+1
        chk_core("wc.a1", 6'b111100, 3'd7, 2'b10, 1'b0);
        tick(8);  // A+9
        chk_core("wc.a9", 6'b111100, 3'd7, 2'b10, 1'b0);
        tick();   // A+10
        chk_core("wc.a10", 6'b111111, 3'd6, 2'b10, 1'b0);

        // Test 4: reserved code ignored, equal width acked without change
        WIDTH_REQ = 2'b11; WIDTH_VALID = 1'b1;
        tick();
        chk_core("rsvd.1", 6'b111111, 3'd6, 2'b10, 1'b0);
        tick(2);
        chk_core("rsvd.3", 6'b111111, 3'd6, 2'b10, 1'b0);
        WIDTH_REQ = 2'b10;
        tick();
        chk_core("same.a", 6'b111111, 3'd6, 2'b10, 1'b1);
        WIDTH_VALID = 1'b0;
        tick();
        chk_core("same.a1", 6'b111111, 3'd6, 2'b10, 1'b0);

        // Test 5: lock loss with a pending request; request held through re-sequence
        WIDTH_REQ = 2'b01; WIDTH_VALID = 1'b1; PLL_LOCK = 1'b0;
        tick();   // L
        chk_core("ll.l", 6'b100000, 3'd1, 2'b10, 1'b0);
        tick(3);
        chk_core("ll.wait", 6'b100000, 3'd1, 2'b10, 1'b0);
        PLL_LOCK = 1'b1;
        tick();   // R = ENB edge
        chk_core("ll.enb", 6'b110000, 3'd2, 2'b10, 1'b0);
        tick(30); // R+30
        chk_core("ll.r30", 6'b111100, 3'd5, 2'b10, 1'b0);
        tick();   // R+31: back in S_RUN, held request not yet acked
        chk_core("ll.run", 6'b111111, 3'd6, 2'b10, 1'b0);
        tick();   // first S_RUN cycle takes the held request
        chk_core("ll.held", 6'b111100, 3'd7, 2'b01, 1'b1);
        WIDTH_VALID = 1'b0;

        // Asynchronous reset mid-sequence acts without a clock edge
        RESET = 1'b1;
        #1;
        chk_core("arst", 6'b000000, 3'd0, 2'b00, 1'b0);

        // Test 2: lock held low until E0+50
        PLL_LOCK = 1'b0;
        tick(2);
        RESET = 1'b0;
        tick();   // E0
        chk_core("lk.e0", 6'b100000, 3'd1, 2'b00, 1'b0);
        tick(50); // E0+50
        chk_core("lk.e50", 6'b100000, 3'd1, 2'b00, 1'b0);
        chk("lk.lock_err", {7'b0, LOCK_ERR}, 8'h0);
        PLL_LOCK = 1'b1;
        tick();   // E0+51
        chk_core("lk.e51", 6'b110000, 3'd2, 2'b00, 1'b0);
        tick(18); // E0+69
        chk_core("lk.e69", 6'b110000, 3'd2, 2'b00, 1'b0);
        tick();   // E0+70
        chk_core("lk.e70", 6'b111000, 3'd3, 2'b00, 1'b0);
        tick(11); // E0+81
        chk_core("lk.e81", 6'b111100, 3'd5, 2'b00, 1'b0);
        tick();   // E0+82
        chk_core("lk.e82", 6'b111111, 3'd6, 2'b00, 1'b0);

`ifdef TX_BRINGUP_LOCK_TIMEOUT_EN
        // Test 6: watchdog pulses RESET_PLL after 255 lock-wait cycles
        RESET = 1'b1; PLL_LOCK = 1'b0;
        tick(2);
        RESET = 1'b0;
        tick();    // E0
        tick(254); // E0+254
        chk("wd.e254.rpll", {7'b0, RESET_PLL}, 8'h1);
        chk("wd.e254.err",  {7'b0, LOCK_ERR},  8'h0);
        tick();    // E0+255
        chk("wd.e255.rpll", {7'b0, RESET_PLL}, 8'h0);
        chk("wd.e255.err",  {7'b0, LOCK_ERR},  8'h1);
        tick();    // E0+256
        chk("wd.e256.rpll", {7'b0, RESET_PLL}, 8'h1);
        chk("wd.e256.state", {5'b0, STATE}, 8'h1);
        PLL_LOCK = 1'b1;
        tick(40);
        chk("wd.sticky", {7'b0, LOCK_ERR}, 8'h1);
        chk("wd.ready",  {7'b0, READY},    8'h1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
